// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
// Line directions are listed in scan order; dx is the column step, dy the row step.
package ttt_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_X     = 2'd1,
        CELL_O     = 2'd2
    } cell_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_X    = 2'd1,
        WIN_O    = 2'd2,
        WIN_DRAW = 2'd3
    } winner_e;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_CHECK,
        ST_OVER,
        ST_CLEAR
    } state_e;

    localparam int NUM_BTNS  = 5;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_MARK  = 4;

    // Direction table: 0=(1,0) 1=(0,1) 2=(1,1) 3=(1,-1)
    function automatic logic signed [1:0] dir_dx(input logic [1:0] d);
        return (d == 2'd1) ? 2'sd0 : 2'sd1;
    endfunction

    function automatic logic signed [1:0] dir_dy(input logic [1:0] d);
        case (d)
            2'd0:    return 2'sd0;
            2'd3:    return -2'sd1;
            default: return 2'sd1;
        endcase
    endfunction

endpackage

// File: rtl/ttt_edge_detect.sv
// Rising-edge detector for a vector of debounced button levels.
// History resets high so a button already held at reset must be released before it can fire.
module ttt_edge_detect #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] level_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '1;
        end else begin
            hist_q <= level_i;
        end
    end

    assign rise_o = level_i & ~hist_q;

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game sequencer: board storage, cursor, turn handling and a
// cell-per-cycle win/draw walker that runs after every placed mark.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter  int BOARD_N = 3,
    parameter  int WIN_LEN = 3,
    localparam int CW      = $clog2(BOARD_N)
) (
    input  logic          clk25M,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          left,
    input  logic          right,
    input  logic          mark,
    input  logic [CW-1:0] rd_x,
    input  logic [CW-1:0] rd_y,
    output logic [1:0]    rd_cell,
    output logic [CW-1:0] cursor_x,
    output logic [CW-1:0] cursor_y,
    output logic          turn,
    output logic [1:0]    winner,
    output logic          busy
);

    localparam int CELLS = BOARD_N * BOARD_N;
    localparam int IW    = $clog2(CELLS);
    localparam int MW    = $clog2(CELLS + 1);
    localparam int KW    = $clog2(WIN_LEN + 1);
    // Probe coordinates are signed with headroom so -1 and BOARD_N never alias a real cell.
    localparam int SW    = CW + 2;

    localparam logic [CW-1:0]        LAST  = CW'(BOARD_N - 1);
    localparam logic [CW-1:0]        MID   = CW'((BOARD_N - 1) / 2);
    localparam logic signed [SW-1:0] BOUND = SW'(BOARD_N);
    localparam logic [MW-1:0]        FULL  = MW'(CELLS);
    localparam logic [KW-1:0]        WIN_K = KW'(WIN_LEN);

    function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] x, input logic [CW-1:0] y);
        return IW'(y) * IW'(BOARD_N) + IW'(x);
    endfunction

    function automatic logic signed [SW-1:0] ext2(input logic signed [1:0] v);
        return {{(SW - 2){v[1]}}, v};
    endfunction

    logic [NUM_BTNS-1:0] btn_lvl;
    logic [NUM_BTNS-1:0] btn_rise;

    assign btn_lvl = {mark, right, left, down, up};

    ttt_edge_detect #(
        .W(NUM_BTNS)
    ) u_edge (
        .clk_i  (clk25M),
        .rst_i  (rst),
        .level_i(btn_lvl),
        .rise_o (btn_rise)
    );

    state_e            state_q;
    logic [1:0]        board_q [CELLS];
    logic [CW-1:0]     cur_x_q, cur_y_q;
    logic              turn_q;
    logic [1:0]        winner_q;
    logic [MW-1:0]     moves_q;
    logic [CW-1:0]     px_q, py_q;
    logic [1:0]        p_q;
    logic [1:0]        dir_q;
    logic              side_q;
    logic signed [SW-1:0] cx_q, cy_q;
    logic [KW-1:0]     cnt_q;

    logic [CW-1:0]     cur_x_d, cur_y_d;
    logic [1:0]        cur_cell;
    logic [1:0]        new_code;
    logic [1:0]        dir_nxt;
    logic signed [SW-1:0] px_s, py_s, dx_s, dy_s, ndx_s, ndy_s, step_x, step_y;
    logic              probe_in;
    logic [1:0]        probe_cell;
    logic              probe_hit;
    logic [KW-1:0]     cnt_inc;

    // Up beats down and left beats right; the two axes are independent.
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (btn_rise[BTN_UP]) begin
            if (cur_y_q != '0) cur_y_d = cur_y_q - CW'(1);
        end else if (btn_rise[BTN_DOWN]) begin
            if (cur_y_q != LAST) cur_y_d = cur_y_q + CW'(1);
        end
        if (btn_rise[BTN_LEFT]) begin
            if (cur_x_q != '0) cur_x_d = cur_x_q - CW'(1);
        end else if (btn_rise[BTN_RIGHT]) begin
            if (cur_x_q != LAST) cur_x_d = cur_x_q + CW'(1);
        end
    end

    assign cur_cell = board_q[cell_idx(cur_x_q, cur_y_q)];
    assign new_code = {turn_q, ~turn_q};

    assign px_s    = {2'b00, px_q};
    assign py_s    = {2'b00, py_q};
    assign dx_s    = ext2(dir_dx(dir_q));
    assign dy_s    = ext2(dir_dy(dir_q));
    assign dir_nxt = dir_q + 2'd1;
    assign ndx_s   = ext2(dir_dx(dir_nxt));
    assign ndy_s   = ext2(dir_dy(dir_nxt));
    assign step_x  = side_q ? -dx_s : dx_s;
    assign step_y  = side_q ? -dy_s : dy_s;

    assign probe_in   = !cx_q[SW-1] && !cy_q[SW-1] && (cx_q < BOUND) && (cy_q < BOUND);
    assign probe_cell = probe_in ? board_q[cell_idx(cx_q[CW-1:0], cy_q[CW-1:0])] : CELL_EMPTY;
    assign probe_hit  = probe_in && (probe_cell == p_q);
    assign cnt_inc    = cnt_q + KW'(1);

    always_ff @(posedge clk25M) begin
        if (rst) begin
            state_q <= ST_PLAY;
            for (int i = 0; i < CELLS; i++) board_q[i] <= CELL_EMPTY;
            cur_x_q  <= MID;
            cur_y_q  <= MID;
            turn_q   <= 1'b0;
            winner_q <= WIN_NONE;
            moves_q  <= '0;
            px_q     <= '0;
            py_q     <= '0;
            p_q      <= CELL_EMPTY;
            dir_q    <= '0;
            side_q   <= 1'b0;
            cx_q     <= '0;
            cy_q     <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    cur_x_q <= cur_x_d;
                    cur_y_q <= cur_y_d;
                    if (btn_rise[BTN_MARK] && cur_cell == CELL_EMPTY) begin
                        board_q[cell_idx(cur_x_q, cur_y_q)] <= new_code;
                        p_q     <= new_code;
                        px_q    <= cur_x_q;
                        py_q    <= cur_y_q;
                        moves_q <= moves_q + MW'(1);
                        dir_q   <= 2'd0;
                        side_q  <= 1'b0;
                        cnt_q   <= KW'(1);
                        cx_q    <= {2'b00, cur_x_q} + ext2(dir_dx(2'd0));
                        cy_q    <= {2'b00, cur_y_q} + ext2(dir_dy(2'd0));
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (probe_hit && cnt_inc == WIN_K) begin
                        winner_q <= p_q;
                        state_q  <= ST_OVER;
                    end else if (probe_hit) begin
                        cnt_q <= cnt_inc;
                        cx_q  <= cx_q + step_x;
                        cy_q  <= cy_q + step_y;
                    end else if (!side_q) begin
                        side_q <= 1'b1;
                        cx_q   <= px_s - dx_s;
                        cy_q   <= py_s - dy_s;
                    end else if (dir_q != 2'd3) begin
                        dir_q  <= dir_nxt;
                        side_q <= 1'b0;
                        cnt_q  <= KW'(1);
                        cx_q   <= px_s + ndx_s;
                        cy_q   <= py_s + ndy_s;
                    end else if (moves_q == FULL) begin
                        winner_q <= WIN_DRAW;
                        state_q  <= ST_OVER;
                    end else begin
                        turn_q  <= ~turn_q;
                        state_q <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    cur_x_q <= cur_x_d;
                    cur_y_q <= cur_y_d;
                    if (btn_rise[BTN_MARK]) state_q <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    for (int i = 0; i < CELLS; i++) board_q[i] <= CELL_EMPTY;
                    moves_q  <= '0;
                    winner_q <= WIN_NONE;
                    turn_q   <= 1'b0;
                    state_q  <= ST_PLAY;
                end
                default: state_q <= ST_PLAY;
            endcase
        end
    end

    assign rd_cell  = (rd_x <= LAST && rd_y <= LAST) ? board_q[cell_idx(rd_x, rd_y)] : CELL_EMPTY;
    assign cursor_x = cur_x_q;
    assign cursor_y = cur_y_q;
    assign turn     = turn_q;
    assign winner   = winner_q;
    assign busy     = (state_q == ST_CHECK);

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: directed games plus random button traffic against a
// board-level reference model that scores lines by counting whole runs.
module tb_ttt_game_ctrl;

    localparam int N  = 3;
    localparam int WL = 3;

    logic       clk25M;
    logic       rst;
    logic       up, down, left, right, mark;
    logic [1:0] rd_x, rd_y;
    logic [1:0] rd_cell;
    logic [1:0] cursor_x, cursor_y;
    logic       turn;
    logic [1:0] winner;
    logic       busy;

    ttt_game_ctrl #(.BOARD_N(N), .WIN_LEN(WL)) dut (
        .clk25M  (clk25M),
        .rst     (rst),
        .up      (up),
        .down    (down),
        .left    (left),
        .right   (right),
        .mark    (mark),
        .rd_x    (rd_x),
        .rd_y    (rd_y),
        .rd_cell (rd_cell),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .turn    (turn),
        .winner  (winner),
        .busy    (busy)
    );

    initial clk25M = 1'b0;
    always #20 clk25M = ~clk25M;

    int n_checks = 0;
    int n_errors = 0;
    int span;

    // Reference model state
    int  mb [N][N];
    int  mx, my, mturn, mwin, mmoves;
    bit  mover;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk25M);
        #1;
    endtask

    function automatic int cell_at(int x, int y);
        if (x < 0 || y < 0 || x >= N || y >= N) return -1;
        return mb[y][x];
    endfunction

    function automatic bit line_win(int x, int y, int p);
        int dxs [4] = '{1, 0, 1, 1};
        int dys [4] = '{0, 1, 1, -1};
        for (int d = 0; d < 4; d++) begin
            int run = 1;
            for (int s = -1; s <= 1; s += 2) begin
                int k = 1;
                while (cell_at(x + s*k*dxs[d], y + s*k*dys[d]) == p) begin
                    run++;
                    k++;
                end
            end
            if (run >= WL) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < N; y++)
            for (int x = 0; x < N; x++) mb[y][x] = 0;
        mx = (N - 1) / 2;
        my = (N - 1) / 2;
        mturn = 0; mwin = 0; mmoves = 0; mover = 0;
    endtask

    // lv bits: 0 up, 1 down, 2 left, 3 right, 4 mark; all are fresh rising edges
    task automatic model_step(input logic [4:0] lv);
        if (lv[4]) begin
            if (mover) begin
                for (int y = 0; y < N; y++)
                    for (int x = 0; x < N; x++) mb[y][x] = 0;
                mmoves = 0; mwin = 0; mturn = 0; mover = 0;
            end else if (mb[my][mx] == 0) begin
                mb[my][mx] = mturn + 1;
                mmoves++;
                if (line_win(mx, my, mturn + 1)) begin
                    mwin = mturn + 1; mover = 1;
                end else if (mmoves == N*N) begin
                    mwin = 3; mover = 1;
                end else begin
                    mturn ^= 1;
                end
            end
        end
        if (lv[0])      my = (my > 0) ? my - 1 : 0;
        else if (lv[1]) my = (my < N-1) ? my + 1 : my;
        if (lv[2])      mx = (mx > 0) ? mx - 1 : 0;
        else if (lv[3]) mx = (mx < N-1) ? mx + 1 : mx;
    endtask

    task automatic set_btns(input logic [4:0] lv);
        {mark, right, left, down, up} = lv;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            span++;
            tick();
            n++;
        end
        if (n >= 40) chk("busy_timeout", n, 0);
        tick();
    endtask

    task automatic press(input logic [4:0] lv);
        set_btns(lv);
        model_step(lv);
        span = 0;
        tick();
        set_btns(5'b0);
        wait_idle();
    endtask

    task automatic verify(input string tag);
        chk($sformatf("%s.cursor_x", tag), cursor_x, mx);
        chk($sformatf("%s.cursor_y", tag), cursor_y, my);
        chk($sformatf("%s.turn", tag), turn, mturn);
        chk($sformatf("%s.winner", tag), winner, mwin);
        chk($sformatf("%s.busy", tag), busy, 0);
        for (int y = 0; y < N; y++) begin
            for (int x = 0; x < N; x++) begin
                rd_x = 2'(x);
                rd_y = 2'(y);
                #1;
                chk($sformatf("%s.cell%0d%0d", tag, x, y), rd_cell, mb[y][x]);
            end
        end
    endtask

    task automatic do_reset();
        set_btns(5'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        tick();
    endtask

    task automatic goto(input int x, input int y);
        while (mx < x) press(5'b01000);
        while (mx > x) press(5'b00100);
        while (my < y) press(5'b00010);
        while (my > y) press(5'b00001);
    endtask

    task automatic play(input int x, input int y, input string tag);
        goto(x, y);
        press(5'b10000);
        verify(tag);
        $display("move (%0d,%0d) turn=%0d winner=%0d span=%0d", x, y, turn, winner, span);
    endtask

    initial begin
        rst = 1'b1;
        set_btns(5'b0);
        rd_x = '0;
        rd_y = '0;
        do_reset();
        verify("reset");
        chk("reset.cursor_mid", cursor_x, 1);

        // Cursor saturation
        repeat (5) begin press(5'b01000); verify("sat_right"); end
        chk("sat_x_max", cursor_x, 2);
        repeat (5) begin press(5'b00001); verify("sat_up"); end
        chk("sat_y_min", cursor_y, 0);

        // Held mark writes once; CHECK span bounded
        do_reset();
        set_btns(5'b10000);
        model_step(5'b10000);
        span = 0;
        repeat (10) begin
            tick();
            if (busy === 1'b1) span++;
        end
        set_btns(5'b0);
        wait_idle();
        chk("held_mark_span_ok", (span >= 1 && span <= 8*(WL-1)+1), 1);
        verify("held_mark");
        $display("held mark: busy span=%0d", span);

        // X wins on the top row, then a mark clears the finished game
        do_reset();
        play(0, 0, "xrow1"); play(0, 1, "xrow2"); play(1, 0, "xrow3");
        play(1, 1, "xrow4"); play(2, 0, "xrow5");
        chk("xrow_winner", winner, 1);
        press(5'b00010); verify("over_move");
        press(5'b10000); verify("over_clear");
        chk("over_clear_winner", winner, 0);

        // O wins on the anti-diagonal
        do_reset();
        play(0, 0, "anti1"); play(2, 0, "anti2"); play(0, 1, "anti3");
        play(1, 1, "anti4"); play(2, 2, "anti5"); play(0, 2, "anti6");
        chk("anti_winner", winner, 2);

        // Draw after 9 marks, then restart
        do_reset();
        play(0, 0, "draw1"); play(1, 0, "draw2"); play(2, 0, "draw3");
        play(1, 1, "draw4"); play(0, 1, "draw5"); play(2, 1, "draw6");
        play(1, 2, "draw7"); play(0, 2, "draw8"); play(2, 2, "draw9");
        chk("draw_winner", winner, 3);
        press(5'b10000); verify("draw_clear");
        chk("draw_clear_turn", turn, 0);

        // Occupied cell, simultaneous up+down, edges during CHECK, reset mid-CHECK
        do_reset();
        play(1, 1, "occ1");
        press(5'b10000); verify("occ_again");
        chk("occ_turn_kept", turn, 1);
        press(5'b00011); verify("up_down");
        chk("up_down_row", cursor_y, 0);
        goto(0, 0);
        set_btns(5'b10000);
        model_step(5'b10000);
        tick();
        set_btns(5'b01000);
        tick();
        set_btns(5'b0);
        span = 0;
        wait_idle();
        verify("drop_in_check");
        goto(2, 2);
        set_btns(5'b10000);
        tick();
        set_btns(5'b0);
        chk("busy_before_rst", busy, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        verify("rst_mid_check");
        tick();
        tick();

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            logic [4:0] lv;
            lv = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) lv[4] = 1'b1;
            press(lv);
            verify($sformatf("rnd%0d", i));
            $display("rnd %0d lv=%05b cur=(%0d,%0d) turn=%0d winner=%0d", i, lv, cursor_x, cursor_y, turn, winner);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
